// File: rtl/temp_display_ctrl.sv
// temp_display_ctrl: captures per-channel 12-bit readings, converts them one at a
// time through a shared double-dabble engine and publishes BCD digits on frame_start.
module temp_display_ctrl #(
  parameter int NUM_CH  = 4,
  parameter int SAT_MAX = 999
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [12*NUM_CH-1:0] temp_in,
  input  logic [NUM_CH-1:0]    temp_valid,
  input  logic                 frame_start,
  output logic [12*NUM_CH-1:0] bcd_out,
  output logic [NUM_CH-1:0]    over_out,
  output logic                 busy
);

  localparam int          PTR_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [11:0] SAT_VAL = 12'(SAT_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    STORE = 2'd2
  } state_t;

  state_t                   state_r;
  state_t                   state_next_s;
  logic [NUM_CH-1:0][11:0]  cap_r;
  logic [NUM_CH-1:0]        pend_r;
  logic [NUM_CH-1:0][11:0]  shadow_bcd_r;
  logic [NUM_CH-1:0]        shadow_over_r;
  logic [PTR_W-1:0]         rr_ptr_r;
  logic [PTR_W-1:0]         gnt_r;
  logic [11:0]              work_r;
  logic [11:0]              bcd_acc_r;
  logic [3:0]               cnt_r;
  logic                     sat_r;

  logic                     grant_vld_s;
  logic [PTR_W-1:0]         grant_idx_s;
  logic [PTR_W-1:0]         rr_next_s;
  logic [11:0]              cap_sel_s;
  logic                     sat_s;
  logic [11:0]              operand_s;
  logic [11:0]              adj_s;
  logic                     grant_en_s;
  logic                     conv_en_s;
  logic                     store_en_s;

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  function automatic logic [11:0] dd_adjust(input logic [11:0] acc);
    logic [11:0] res;
    res = 12'd0;
    for (int n = 0; n < 3; n++) begin
      res[4*n +: 4] = (acc[4*n +: 4] >= 4'd5) ? (acc[4*n +: 4] + 4'd3) : acc[4*n +: 4];
    end
    return res;
  endfunction

  // Round-robin search: first pending channel at or after rr_ptr_r, wrapping.
  always_comb begin
    int idx_v;
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    idx_v       = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx_v       = (int'(rr_ptr_r) + k) % NUM_CH;
      grant_idx_s = (pend_r[idx_v] && !grant_vld_s) ? PTR_W'(idx_v) : grant_idx_s;
      grant_vld_s = grant_vld_s | pend_r[idx_v];
    end
  end

  // Operand selection with saturation, pointer advance and per-cycle BCD correction.
  always_comb begin
    rr_next_s = (grant_idx_s == PTR_W'(NUM_CH - 1)) ? '0 : (grant_idx_s + PTR_W'(1));
    cap_sel_s = cap_r[grant_idx_s];
    sat_s     = (cap_sel_s > SAT_VAL);
    operand_s = sat_s ? SAT_VAL : cap_sel_s;
    adj_s     = dd_adjust(bcd_acc_r);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic: one grant, twelve shift cycles, one store cycle.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = grant_vld_s ? CONV : IDLE;
      CONV:    state_next_s = (cnt_r == 4'd11) ? STORE : CONV;
      STORE:   state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // FSM output decode.
  always_comb begin
    grant_en_s = 1'b0;
    conv_en_s  = 1'b0;
    store_en_s = 1'b0;
    case (state_r)
      IDLE:    grant_en_s = grant_vld_s;
      CONV:    conv_en_s  = 1'b1;
      STORE:   store_en_s = 1'b1;
      default: grant_en_s = 1'b0;
    endcase
  end

  // Capture registers and pending flags; a strobe on the granted channel keeps it pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_r  <= '0;
      pend_r <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (temp_valid[i]) begin
          cap_r[i]  <= temp_in[12*i +: 12];
          pend_r[i] <= 1'b1;
        end else if (grant_en_s && (grant_idx_s == PTR_W'(i))) begin
          pend_r[i] <= 1'b0;
        end
      end
    end
  end

  // Conversion engine: load on grant, then correct-and-shift {bcd_acc, work} each CONV cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r  <= '0;
      gnt_r     <= '0;
      work_r    <= 12'd0;
      bcd_acc_r <= 12'd0;
      cnt_r     <= 4'd0;
      sat_r     <= 1'b0;
    end else if (grant_en_s) begin
      rr_ptr_r  <= rr_next_s;
      gnt_r     <= grant_idx_s;
      work_r    <= operand_s;
      sat_r     <= sat_s;
      bcd_acc_r <= 12'd0;
      cnt_r     <= 4'd0;
    end else if (conv_en_s) begin
      {bcd_acc_r, work_r} <= {adj_s, work_r} << 5'd1;
      cnt_r               <= cnt_r + 4'd1;
    end
  end

  // Shadow registers hold finished results until the next frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_bcd_r  <= '0;
      shadow_over_r <= '0;
    end else if (store_en_s) begin
      shadow_bcd_r[gnt_r]  <= bcd_acc_r;
      shadow_over_r[gnt_r] <= sat_r;
    end
  end

  // Display-facing registers change only on frame_start so digits never tear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_out  <= '0;
      over_out <= '0;
      busy     <= 1'b0;
    end else begin
      busy <= (state_next_s != IDLE);
      if (frame_start) begin
        bcd_out  <= shadow_bcd_r;
        over_out <= shadow_over_r;
      end
    end
  end

endmodule

// File: tb/tb_temp_display_ctrl.sv
// Bench for temp_display_ctrl: table of single-channel conversions plus hand-written
// arbitration, tear-free publish, re-strobe and mid-conversion reset sequences.
module tb_temp_display_ctrl;

  localparam int NUM_CH = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [12*NUM_CH-1:0] temp_in;
  logic [NUM_CH-1:0]    temp_valid;
  logic                 frame_start;
  logic [12*NUM_CH-1:0] bcd_out;
  logic [NUM_CH-1:0]    over_out;
  logic                 busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int          ch;
    logic [11:0] bcd;
    logic        over;
  } sb_t;

  typedef struct {
    int          ch;
    logic [11:0] raw;
    logic [11:0] bcd;
    logic        over;
  } vec_t;

  sb_t         sb_q[$];
  vec_t        vecs[8];
  logic [11:0] disp_bcd[NUM_CH];

  temp_display_ctrl #(.NUM_CH(NUM_CH), .SAT_MAX(999)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .temp_in     (temp_in),
    .temp_valid  (temp_valid),
    .frame_start (frame_start),
    .bcd_out     (bcd_out),
    .over_out    (over_out),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int ch, input logic [11:0] val, output int t);
    temp_in[12*ch +: 12] = val;
    temp_valid[ch]       = 1'b1;
    tick();
    temp_valid = '0;
    t          = cyc;
  endtask

  task automatic push(input int ch, input logic [11:0] bcd, input logic over);
    sb_t e;
    e.ch   = ch;
    e.bcd  = bcd;
    e.over = over;
    sb_q.push_back(e);
  endtask

  task automatic publish();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Waits for busy to be seen high and then low; reports the cycle of the fall.
  task automatic wait_idle(output int t, output int hi);
    int n;
    bit seen;
    bit done;
    n    = 0;
    seen = 1'b0;
    done = 1'b0;
    hi   = 0;
    t    = 0;
    while (!done && n < 200) begin
      tick();
      n++;
      if (busy) begin
        seen = 1'b1;
        hi++;
      end else if (seen) begin
        done = 1'b1;
        t    = cyc;
      end
    end
    chk("idle_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic sb_check();
    sb_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty: actual=0 entries expected=1 or more");
    end else begin
      e = sb_q.pop_front();
      chk($sformatf("bcd_ch%0d", e.ch), {20'd0, bcd_out[12*e.ch +: 12]}, {20'd0, e.bcd});
      chk($sformatf("over_ch%0d", e.ch), {31'd0, over_out[e.ch]}, {31'd0, e.over});
      disp_bcd[e.ch] = e.bcd;
    end
  endtask

  initial begin
    int  t0;
    int  t1;
    int  hi;
    bit  busy_seen;

    vecs[0] = '{0, 12'd273,  12'h273, 1'b0};
    vecs[1] = '{1, 12'd4095, 12'h999, 1'b1};
    vecs[2] = '{1, 12'd999,  12'h999, 1'b0};
    vecs[3] = '{1, 12'd1000, 12'h999, 1'b1};
    vecs[4] = '{1, 12'd0,    12'h000, 1'b0};
    vecs[5] = '{2, 12'd7,    12'h007, 1'b0};
    vecs[6] = '{0, 12'd58,   12'h058, 1'b0};
    vecs[7] = '{3, 12'd512,  12'h512, 1'b0};
    for (int c = 0; c < NUM_CH; c++) disp_bcd[c] = 12'h000;

    rst_n       = 1'b0;
    temp_in     = '0;
    temp_valid  = '0;
    frame_start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("reset_bcd_lo", bcd_out[31:0], 32'd0);
    chk("reset_bcd_hi", {16'd0, bcd_out[47:32]}, 32'd0);
    chk("reset_over", {28'd0, over_out}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);

    // Single-channel conversions, latency and saturation boundaries.
    for (int i = 0; i < 8; i++) begin
      strobe(vecs[i].ch, vecs[i].raw, t0);
      push(vecs[i].ch, vecs[i].bcd, vecs[i].over);
      wait_idle(t1, hi);
      chk("latency", t1 - t0, 32'd14);
      chk("busy_len", hi, 32'd13);
      repeat (4) tick();
      publish();
      sb_check();
    end

    // All four channels strobed together; rr_ptr is back at 0.
    temp_in    = {12'd40, 12'd30, 12'd20, 12'd10};
    temp_valid = 4'hF;
    tick();
    temp_valid = '0;
    t0         = cyc;
    push(0, 12'h010, 1'b0);
    push(1, 12'h020, 1'b0);
    push(2, 12'h030, 1'b0);
    push(3, 12'h040, 1'b0);
    for (int j = 0; j < 4; j++) begin
      wait_idle(t1, hi);
      chk("arb_slot", t1 - t0, 14 * (j + 1));
      publish();
      sb_check();
      if (j < 3) chk("arb_order", {20'd0, bcd_out[12*(j+1) +: 12]}, {20'd0, disp_bcd[j+1]});
    end

    // frame_start on the STORE edge publishes the previous shadow.
    strobe(2, 12'd55, t0);
    push(2, 12'h055, 1'b0);
    repeat (13) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("tear_cycle", cyc - t0, 32'd14);
    chk("tear_unchanged", {20'd0, bcd_out[35:24]}, {20'd0, disp_bcd[2]});
    chk("tear_busy", {31'd0, busy}, 32'd0);
    repeat (3) tick();
    publish();
    sb_check();

    // Re-strobe during own conversion yields a second conversion.
    strobe(0, 12'd100, t0);
    push(0, 12'h100, 1'b0);
    repeat (4) tick();
    strobe(0, 12'd200, t1);
    push(0, 12'h200, 1'b0);
    wait_idle(t1, hi);
    chk("restrobe_first", t1 - t0, 32'd14);
    publish();
    sb_check();
    wait_idle(t1, hi);
    chk("restrobe_second", t1 - t0, 32'd28);
    publish();
    sb_check();

    // Reset in the middle of a conversion.
    strobe(3, 12'd512, t0);
    repeat (6) tick();
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_bcd_lo", bcd_out[31:0], 32'd0);
    chk("rst_bcd_hi", {16'd0, bcd_out[47:32]}, 32'd0);
    chk("rst_over", {28'd0, over_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    tick();
    rst_n     = 1'b1;
    busy_seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      busy_seen = busy_seen | busy;
    end
    chk("rst_no_resume", {31'd0, busy_seen}, 32'd0);
    publish();
    chk("rst_pub_lo", bcd_out[31:0], 32'd0);
    chk("rst_pub_hi", {16'd0, bcd_out[47:32]}, 32'd0);
    chk("rst_pub_over", {28'd0, over_out}, 32'd0);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
